// File: rtl/coreriscv_axi4_queue_8_pkg.sv
// coreriscv_axi4_queue_8_pkg: TileLink Acquire field widths and the 111-bit payload type shared by ROM slave and queues
package coreriscv_axi4_queue_8_pkg;
    localparam int ADDR_BLOCK_W = 26;
    localparam int XACT_ID_W    = 2;
    localparam int BEAT_W       = 3;
    localparam int A_TYPE_W     = 3;
    localparam int UNION_W      = 12;
    localparam int DATA_W       = 64;
    typedef struct packed {
        logic [ADDR_BLOCK_W-1:0] addr_block;
        logic [XACT_ID_W-1:0]    client_xact_id;
        logic [BEAT_W-1:0]       addr_beat;
        logic                    is_builtin_type;
        logic [A_TYPE_W-1:0]     a_type;
        logic [UNION_W-1:0]      union_bits;
        logic [DATA_W-1:0]       data;
    } acquire_t;
    localparam int ACQUIRE_W = $bits(acquire_t);
endpackage

// File: rtl/coreriscv_axi4_queue_8.sv
// coreriscv_axi4_queue_8: single-entry non-flow non-pipe queue for one TileLink Acquire beat
// Ports: clk/reset (async active-high); io_enq_* producer handshake and fields;
// io_deq_* consumer handshake and stored fields; io_count occupancy (0/1).
module coreriscv_axi4_queue_8
    import coreriscv_axi4_queue_8_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    output logic                    io_enq_ready,
    input  logic                    io_enq_valid,
    input  logic [ADDR_BLOCK_W-1:0] io_enq_bits_addr_block,
    input  logic [XACT_ID_W-1:0]    io_enq_bits_client_xact_id,
    input  logic [BEAT_W-1:0]       io_enq_bits_addr_beat,
    input  logic                    io_enq_bits_is_builtin_type,
    input  logic [A_TYPE_W-1:0]     io_enq_bits_a_type,
    input  logic [UNION_W-1:0]      io_enq_bits_union,
    input  logic [DATA_W-1:0]       io_enq_bits_data,
    input  logic                    io_deq_ready,
    output logic                    io_deq_valid,
    output logic [ADDR_BLOCK_W-1:0] io_deq_bits_addr_block,
    output logic [XACT_ID_W-1:0]    io_deq_bits_client_xact_id,
    output logic [BEAT_W-1:0]       io_deq_bits_addr_beat,
    output logic                    io_deq_bits_is_builtin_type,
    output logic [A_TYPE_W-1:0]     io_deq_bits_a_type,
    output logic [UNION_W-1:0]      io_deq_bits_union,
    output logic [DATA_W-1:0]       io_deq_bits_data,
    output logic                    io_count
);
    logic     r_full;
    acquire_t r_payload;
    acquire_t w_enq_payload;
    logic     w_enq_fire;
    logic     w_deq_fire;

    assign w_enq_payload = '{addr_block:      io_enq_bits_addr_block,
                             client_xact_id:  io_enq_bits_client_xact_id,
                             addr_beat:       io_enq_bits_addr_beat,
                             is_builtin_type: io_enq_bits_is_builtin_type,
                             a_type:          io_enq_bits_a_type,
                             union_bits:      io_enq_bits_union,
                             data:            io_enq_bits_data};
    // Fire conditions are mutually exclusive by construction: no flow, no pipe.
    assign w_enq_fire = io_enq_valid & ~r_full;
    assign w_deq_fire = io_deq_ready & r_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full    <= 1'b0;
            r_payload <= '0;
        end else if (w_enq_fire) begin
            r_full    <= 1'b1;
            r_payload <= w_enq_payload;
        end else if (w_deq_fire) begin
            r_full    <= 1'b0;
        end
    end

    assign io_enq_ready                = ~r_full;
    assign io_deq_valid                = r_full;
    assign io_count                    = r_full;
    assign io_deq_bits_addr_block      = r_payload.addr_block;
    assign io_deq_bits_client_xact_id  = r_payload.client_xact_id;
    assign io_deq_bits_addr_beat       = r_payload.addr_beat;
    assign io_deq_bits_is_builtin_type = r_payload.is_builtin_type;
    assign io_deq_bits_a_type          = r_payload.a_type;
    assign io_deq_bits_union           = r_payload.union_bits;
    assign io_deq_bits_data            = r_payload.data;
endmodule

// File: tb/tb_coreriscv_axi4_queue_8.sv
// tb_coreriscv_axi4_queue_8: randomized and directed checks of the one-entry acquire queue against a queue-based model
module tb_coreriscv_axi4_queue_8;
    import coreriscv_axi4_queue_8_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_enq_ready, io_enq_valid = 1'b0;
    logic [25:0] io_enq_bits_addr_block = '0;
    logic [1:0]  io_enq_bits_client_xact_id = '0;
    logic [2:0]  io_enq_bits_addr_beat = '0;
    logic        io_enq_bits_is_builtin_type = 1'b0;
    logic [2:0]  io_enq_bits_a_type = '0;
    logic [11:0] io_enq_bits_union = '0;
    logic [63:0] io_enq_bits_data = '0;
    logic        io_deq_ready = 1'b0, io_deq_valid;
    logic [25:0] io_deq_bits_addr_block;
    logic [1:0]  io_deq_bits_client_xact_id;
    logic [2:0]  io_deq_bits_addr_beat;
    logic        io_deq_bits_is_builtin_type;
    logic [2:0]  io_deq_bits_a_type;
    logic [11:0] io_deq_bits_union;
    logic [63:0] io_deq_bits_data;
    logic        io_count;
    int          n_chk = 0, n_pass = 0;
    acquire_t    mq[$];
    acquire_t    shown = '0;

    coreriscv_axi4_queue_8 dut (
        .clk(clk), .reset(reset),
        .io_enq_ready(io_enq_ready), .io_enq_valid(io_enq_valid),
        .io_enq_bits_addr_block(io_enq_bits_addr_block),
        .io_enq_bits_client_xact_id(io_enq_bits_client_xact_id),
        .io_enq_bits_addr_beat(io_enq_bits_addr_beat),
        .io_enq_bits_is_builtin_type(io_enq_bits_is_builtin_type),
        .io_enq_bits_a_type(io_enq_bits_a_type),
        .io_enq_bits_union(io_enq_bits_union),
        .io_enq_bits_data(io_enq_bits_data),
        .io_deq_ready(io_deq_ready), .io_deq_valid(io_deq_valid),
        .io_deq_bits_addr_block(io_deq_bits_addr_block),
        .io_deq_bits_client_xact_id(io_deq_bits_client_xact_id),
        .io_deq_bits_addr_beat(io_deq_bits_addr_beat),
        .io_deq_bits_is_builtin_type(io_deq_bits_is_builtin_type),
        .io_deq_bits_a_type(io_deq_bits_a_type),
        .io_deq_bits_union(io_deq_bits_union),
        .io_deq_bits_data(io_deq_bits_data),
        .io_count(io_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic acquire_t deq_view();
        return {io_deq_bits_addr_block, io_deq_bits_client_xact_id, io_deq_bits_addr_beat,
                io_deq_bits_is_builtin_type, io_deq_bits_a_type, io_deq_bits_union, io_deq_bits_data};
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_deq_valid"}, 128'(io_deq_valid), 128'(mq.size() == 1));
        chk({tag, "_enq_ready"}, 128'(io_enq_ready), 128'(mq.size() == 0));
        chk({tag, "_count"},     128'(io_count),     128'(mq.size()));
        chk({tag, "_deq_bits"},  128'(deq_view()),   128'(mq.size() != 0 ? mq[0] : shown));
    endtask

    function automatic acquire_t rnd_payload();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[110:0];
    endfunction

    // One clock cycle: drive at negedge, check register outputs, let the model see the edge.
    task automatic cyc(input string tag, input logic ev, input logic dr, input acquire_t p);
        io_enq_valid = ev;
        io_deq_ready = dr;
        {io_enq_bits_addr_block, io_enq_bits_client_xact_id, io_enq_bits_addr_beat,
         io_enq_bits_is_builtin_type, io_enq_bits_a_type, io_enq_bits_union, io_enq_bits_data} = p;
        #1;
        check_outputs(tag);
        @(posedge clk);
        if (mq.size() == 0) begin
            if (ev) begin
                mq.push_back(p);
                shown = p;
            end
        end else if (dr) begin
            void'(mq.pop_front());
        end
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next rising edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        mq.delete();
        shown = '0;
        #1;
        check_outputs(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    acquire_t t2, p;
    int idx;
    bit was_empty;

    initial begin
        t2 = '{addr_block: 26'h0000040, client_xact_id: 2'd2, addr_beat: 3'd3, is_builtin_type: 1'b1,
               a_type: 3'd1, union_bits: 12'h1C1, data: 64'hDEADBEEF_CAFEF00D};
        @(negedge clk);
        reset = 1'b0;
        cyc("idle", 1'b0, 1'b0, '0);
        // Fill with random data, then reset asynchronously
        cyc("prefill", 1'b1, 1'b0, rnd_payload());
        async_reset("reset1");
        // Single transfer with the reference payload
        cyc("t2_enq", 1'b1, 1'b0, t2);
        chk("t2_data_now", 128'(io_deq_bits_data), 128'(64'hDEADBEEF_CAFEF00D));
        chk("t2_addr_now", 128'(io_deq_bits_addr_block), 128'(26'h0000040));
        cyc("t2_full", 1'b0, 1'b1, '0);
        cyc("t2_empty", 1'b0, 1'b0, '0);
        // Backpressure: entry held while new data is offered
        cyc("bp_fill", 1'b1, 1'b0, rnd_payload());
        for (int i = 0; i < 10; i++) cyc("bp_hold", 1'b1, 1'b0, rnd_payload());
        // No pipe: a full queue dequeues but refuses the simultaneous enqueue
        p = rnd_payload();
        cyc("nopipe", 1'b1, 1'b1, p);
        cyc("nopipe_next", 1'b1, 1'b0, p);
        chk("nopipe_bits", 128'(deq_view()), 128'(p));
        cyc("nopipe_drain", 1'b0, 1'b1, '0);
        // Streaming 8 entries with data 0..7
        idx = 0;
        while (idx < 8 || mq.size() != 0) begin
            p = rnd_payload();
            p.data = 64'(idx);
            was_empty = mq.size() == 0;
            cyc("stream", idx < 8, 1'b1, p);
            if (was_empty && idx < 8) idx++;
        end
        chk("stream_last", 128'(io_deq_bits_data), 128'(64'd7));
        // Reset mid-operation then a fresh transfer
        cyc("mid_fill", 1'b1, 1'b0, rnd_payload());
        async_reset("reset2");
        cyc("re_enq", 1'b1, 1'b0, t2);
        cyc("re_full", 1'b0, 1'b1, '0);
        cyc("re_empty", 1'b0, 1'b0, '0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), rnd_payload());
            if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
